// File: rtl/key_debounce_irq.sv
// User-key conditioning: 2-flop sync + per-key debounce, press-event pending
// register with W1C clear, interrupt mask, and a small bus-readable register file.

module key_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic stable_o,
  output logic press_o
);
  localparam logic             IDLE     = ACTIVE_LOW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             sync, differ, flip;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign sync   = ACTIVE_LOW ? ~s2_q : s2_q;
  assign differ = (sync != stable_q);
  assign flip   = differ && (cnt_q == CNT_LAST);

  // Any return to the stable level drops the count back to zero.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (differ) begin
      if (flip) stable_d = sync;
      else      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= IDLE;
      s2_q     <= IDLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = flip & sync;
endmodule

module key_debounce_irq #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             sys_rstn,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_stable,
  input  logic [3:0]       addr,
  input  logic             we,
  input  logic [3:0]       byteen,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             irq
);
  localparam logic [1:0] SEL_STAT = 2'd0;
  localparam logic [1:0] SEL_PEND = 2'd1;
  localparam logic [1:0] SEL_MASK = 2'd2;

  typedef struct packed {
    logic [1:0]       sel;
    logic             wr;
    logic [WIDTH-1:0] data;
  } bus_req_t;

  bus_req_t         req;
  logic [WIDTH-1:0] stable_w, press_w;
  logic [WIDTH-1:0] pend_q, pend_d, mask_q, mask_d, clr;
  logic             irq_q;
  logic             unused_bits;

  always_comb begin
    req.sel  = addr[3:2];
    req.wr   = we & byteen[0];
    req.data = wdata[WIDTH-1:0];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    key_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_lane (
      .clk     (clk),
      .rst_n   (sys_rstn),
      .raw_i   (key_raw[i]),
      .stable_o(stable_w[i]),
      .press_o (press_w[i])
    );
  end

  // New presses are OR'd in after the clear so a same-edge set wins.
  always_comb begin
    clr    = (req.wr && req.sel == SEL_PEND) ? req.data : '0;
    pend_d = (pend_q & ~clr) | press_w;
    mask_d = (req.wr && req.sel == SEL_MASK) ? req.data : mask_q;
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      pend_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      irq_q  <= |(pend_d & mask_d);
    end
  end

  always_comb begin
    rdata = '0;
    unique case (req.sel)
      SEL_STAT: rdata[WIDTH-1:0] = stable_w;
      SEL_PEND: rdata[WIDTH-1:0] = pend_q;
      SEL_MASK: rdata[WIDTH-1:0] = mask_q;
      default:  rdata = '0;
    endcase
  end

  assign key_stable  = stable_w;
  assign irq         = irq_q;
  assign unused_bits = ^{addr[1:0], byteen[3:1], wdata};
endmodule

// File: tb/tb_key_debounce_irq.sv
// Directed bench for key_debounce_irq: stimulus queues expected register views,
// a negedge monitor pops and compares them.

module tb_key_debounce_irq;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          sys_rstn;
  logic [W-1:0]  key_raw;
  logic [W-1:0]  key_stable;
  logic [3:0]    addr;
  logic          we;
  logic [3:0]    byteen;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          irq;

  key_debounce_irq #(
    .WIDTH(W), .DEBOUNCE_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .sys_rstn(sys_rstn), .key_raw(key_raw), .key_stable(key_stable),
    .addr(addr), .we(we), .byteen(byteen), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic [W-1:0] st;
    logic        irq;
  } exp_t;

  exp_t   q[$];
  logic   obs_vld = 1'b0;
  int     n_chk  = 0;
  int     n_pass = 0;

  // Hand-maintained expected register state.
  logic [W-1:0] m_stable, m_pend, m_mask;

  always @(negedge clk) begin
    if (obs_vld) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL queue_underrun: monitor saw a sample with nothing expected");
      end else begin
        exp_t e;
        e = q.pop_front();
        n_chk++;
        if (rdata === e.rd) n_pass++;
        else $display("FAIL %s.rdata: got %h want %h", e.name, rdata, e.rd);
        n_chk++;
        if (key_stable === e.st) n_pass++;
        else $display("FAIL %s.key_stable: got %h want %h", e.name, key_stable, e.st);
        n_chk++;
        if (irq === e.irq) n_pass++;
        else $display("FAIL %s.irq: got %b want %b", e.name, irq, e.irq);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Queue the expected view for offset a, then spend one cycle being sampled.
  task automatic check(input string name, input logic [3:0] a);
    exp_t e;
    logic [31:0] r;
    r = '0;
    case (a[3:2])
      2'd0: r[W-1:0] = m_stable;
      2'd1: r[W-1:0] = m_pend;
      2'd2: r[W-1:0] = m_mask;
      default: r = '0;
    endcase
    e.name = name;
    e.rd   = r;
    e.st   = m_stable;
    e.irq  = |(m_pend & m_mask);
    addr   = a;
    q.push_back(e);
    obs_vld = 1'b1;
    tick();
    obs_vld = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; wdata = d; byteen = be; we = 1'b1;
    tick();
    we = 1'b0; byteen = 4'h0; wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rstn = 1'b0; key_raw = 8'h00; addr = 4'h0; we = 1'b0; byteen = 4'h0; wdata = '0;
    m_stable = '0; m_pend = '0; m_mask = '0;
    tick(3);

    // 1. reset state, keys apparently pressed but held in reset
    check("rst_off0", 4'h0);
    check("rst_off4", 4'h4);
    check("rst_off8", 4'h8);
    check("rst_off12", 4'hC);
    key_raw = 8'hFF;
    sys_rstn = 1'b1;
    tick(8);
    check("idle_off0", 4'h0);
    check("idle_off4", 4'h4);

    // 2. clean press of key 0: visible exactly 6 edges after the raw edge
    key_raw = 8'hFE;
    tick(5);
    check("press_edge5", 4'h0);
    m_stable = 8'h01; m_pend = 8'h01;
    check("press_edge6", 4'h0);
    check("press_pend", 4'h4);
    wr(4'h8, 32'h0000_0001, 4'b0001);
    m_mask = 8'h01;
    check("mask_irq", 4'h8);

    // 3. key 1 bounces with 2-cycle half-period, then rests released
    for (int i = 0; i < 10; i++) begin
      key_raw[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    tick(6);
    check("bounce_stat", 4'h0);
    check("bounce_pend", 4'h4);

    // 4. W1C clear, then a clear colliding with a press on the same edge
    key_raw = 8'hFC;
    tick(6);
    m_stable = 8'h03; m_pend = 8'h03;
    check("pend_03", 4'h4);
    wr(4'h4, 32'h0000_0001, 4'b0001);
    m_pend = 8'h02;
    check("w1c_bit0", 4'h4);
    key_raw = 8'hF8;
    tick(5);
    wr(4'h4, 32'h0000_0004, 4'b0001);
    m_stable = 8'h07; m_pend = 8'h06;
    check("set_wins", 4'h4);

    // 5. byte enables and dead offsets
    wr(4'h8, 32'h0000_00FF, 4'b0010);
    check("be_ignored", 4'h8);
    wr(4'h0, 32'h0000_00FF, 4'b0001);
    check("off0_write", 4'h0);
    wr(4'hC, 32'hFFFF_FFFF, 4'b1111);
    check("off12_read", 4'hC);
    check("off12_noside", 4'h8);

    // 6. release makes no event; reset mid-press re-qualifies after release
    key_raw = 8'hF9;
    tick(6);
    m_stable = 8'h06;
    check("release_stat", 4'h0);
    check("release_pend", 4'h4);
    key_raw = 8'hF1;
    tick(3);
    sys_rstn = 1'b0;
    tick();
    sys_rstn = 1'b1;
    m_stable = '0; m_pend = '0; m_mask = '0;
    check("rst_mid_pend", 4'h4);
    tick(4);
    check("requal_edge5", 4'h4);
    m_stable = 8'h0E; m_pend = 8'h0E;
    check("requal_edge6", 4'h4);
    check("requal_mask", 4'h8);

    @(negedge clk);
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL queue_leftover: got %0d entries want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
